// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared widths, state encoding and byte-merge helper for the data-memory responder
package dmem_resp_pkg;

    localparam int DATA_BUS   = 32;
    localparam int BYTE_W     = 8;
    localparam int DM_WEA_W   = DATA_BUS / BYTE_W;
    localparam int DM_ADDR_W  = 32;
    localparam int DMEM_DEPTH = 1024;

    typedef enum logic {
        DMEM_IDLE   = 1'b0,
        DMEM_SECOND = 1'b1
    } dmem_state_t;

    // Bytes of new_word selected by wea replace the matching bytes of base_word.
    function automatic logic [DATA_BUS-1:0] byte_merge(
        input logic [DATA_BUS-1:0] base_word,
        input logic [DATA_BUS-1:0] new_word,
        input logic [DM_WEA_W-1:0] wea
    );
        logic [DATA_BUS-1:0] merged;
        merged = base_word;
        for (int b = 0; b < DM_WEA_W; b++) begin
            if (wea[b]) begin
                merged[BYTE_W*b +: BYTE_W] = new_word[BYTE_W*b +: BYTE_W];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word RAM with one byte-enabled synchronous write port and two asynchronous read ports
module dmem_ram
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IW-1:0]       waddr,
    input  logic [DM_WEA_W-1:0] wea,
    input  logic [DATA_BUS-1:0] wdata,
    input  logic [IW-1:0]       raddr0,
    input  logic [IW-1:0]       raddr1,
    output logic [DATA_BUS-1:0] rdata0,
    output logic [DATA_BUS-1:0] rdata1
);

    logic [DATA_BUS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DM_WEA_W; b++) begin
                if (wea[b]) begin
                    mem[waddr][BYTE_W*b +: BYTE_W] <= wdata[BYTE_W*b +: BYTE_W];
                end
            end
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - dual-lane data-memory responder: range check, store serialisation, lane 0 to lane 1 forwarding
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int                   DEPTH = DMEM_DEPTH,
    parameter logic [DM_ADDR_W-1:0] BASE  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_w0,
    input  logic [DM_WEA_W-1:0]  wea0,
    input  logic [DM_ADDR_W-1:0] addr0,
    input  logic [DATA_BUS-1:0]  wdata0,
    output logic [DATA_BUS-1:0]  rdata0,
    input  logic                 mem_w1,
    input  logic [DM_WEA_W-1:0]  wea1,
    input  logic [DM_ADDR_W-1:0] addr1,
    input  logic [DATA_BUS-1:0]  wdata1,
    output logic [DATA_BUS-1:0]  rdata1,
    output logic                 stop,
    output logic                 err
);

    localparam int IW = $clog2(DEPTH);

    dmem_state_t state, state_next;

    logic [DM_ADDR_W-3:0] woff0, woff1;
    logic                 in0, in1, wr0, wr1, bad0, bad1;
    logic [IW-1:0]        idx0, idx1, widx;
    logic                 we;
    logic [DM_WEA_W-1:0]  wsel_wea;
    logic [DATA_BUS-1:0]  wsel_data, ram_r0, ram_r1;
    logic                 unused_addr_bits;

    // BASE is word aligned, so the byte offset bits never affect indexing or range.
    assign unused_addr_bits = ^{addr0[1:0], addr1[1:0]};
    assign woff0 = addr0[DM_ADDR_W-1:2] - BASE[DM_ADDR_W-1:2];
    assign woff1 = addr1[DM_ADDR_W-1:2] - BASE[DM_ADDR_W-1:2];
    assign in0   = (addr0[DM_ADDR_W-1:2] >= BASE[DM_ADDR_W-1:2]) && (woff0 < (DM_ADDR_W-2)'(DEPTH));
    assign in1   = (addr1[DM_ADDR_W-1:2] >= BASE[DM_ADDR_W-1:2]) && (woff1 < (DM_ADDR_W-2)'(DEPTH));
    assign idx0  = woff0[IW-1:0];
    assign idx1  = woff1[IW-1:0];
    assign wr0   = mem_w0 && (wea0 != '0) && in0;
    assign wr1   = mem_w1 && (wea1 != '0) && in1;
    assign bad0  = (mem_w0 || (wea0 == '0)) && !in0;
    assign bad1  = (mem_w1 || (wea1 == '0)) && !in1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DMEM_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The single write port takes lane 0 first; a same-cycle lane 1 store waits one held cycle.
    always_comb begin
        state_next = state;
        stop       = 1'b0;
        we         = 1'b0;
        widx       = idx0;
        wsel_wea   = wea0;
        wsel_data  = wdata0;
        unique case (state)
            DMEM_IDLE: begin
                if (wr0) begin
                    we = 1'b1;
                    if (wr1) begin
                        stop       = 1'b1;
                        state_next = DMEM_SECOND;
                    end
                end else if (wr1) begin
                    we        = 1'b1;
                    widx      = idx1;
                    wsel_wea  = wea1;
                    wsel_data = wdata1;
                end
            end
            DMEM_SECOND: begin
                state_next = DMEM_IDLE;
                if (wr1) begin
                    we        = 1'b1;
                    widx      = idx1;
                    wsel_wea  = wea1;
                    wsel_data = wdata1;
                end
            end
        endcase
        if (rst) begin
            we = 1'b0;
        end
    end

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (widx),
        .wea    (wsel_wea),
        .wdata  (wsel_data),
        .raddr0 (idx0),
        .raddr1 (idx1),
        .rdata0 (ram_r0),
        .rdata1 (ram_r1)
    );

    // In SECOND the RAM already holds lane 0's bytes, so only IDLE forwards.
    always_comb begin
        rdata0 = in0 ? ram_r0 : '0;
        rdata1 = '0;
        if (in1) begin
            if ((state == DMEM_IDLE) && wr0 && (idx0 == idx1)) begin
                rdata1 = byte_merge(ram_r1, wdata0, wea0);
            end else begin
                rdata1 = ram_r1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bad0 || bad1) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed and randomized self-checking bench for dmem_resp against a word-array model
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_w0, mem_w1;
    logic [3:0]  wea0, wea1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        stop, err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [0:127];

    dmem_resp #(.DEPTH(1024), .BASE(32'h0000_0000)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_w0 (mem_w0),
        .wea0   (wea0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .rdata0 (rdata0),
        .mem_w1 (mem_w1),
        .wea1   (wea1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .rdata1 (rdata1),
        .stop   (stop),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] en);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = en[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic drive(input logic w0, input logic [3:0] e0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic w1, input logic [3:0] e1, input logic [31:0] a1, input logic [31:0] d1);
        mem_w0 = w0; wea0 = e0; addr0 = a0; wdata0 = d0;
        mem_w1 = w1; wea1 = e1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
        drive(1'b0, 4'h0, a0, 32'h0, 1'b0, 4'h0, a1, 32'h0);
        #4;
        check({tag, "_rdata0"}, rdata0, e0);
        check({tag, "_rdata1"}, rdata1, e1);
        check({tag, "_stop"}, 32'(stop), 32'h0);
        tick();
    endtask

    initial begin
        logic [31:0] v, a0, a1, d0, d1, exp1;
        logic [3:0]  e0, e1;
        logic        w0, w1, ew0, ew1;
        int          i0, i1;

        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        #4;
        check("reset_stop", 32'(stop), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 96; i++) begin
            v = $urandom;
            drive(1'b1, 4'hF, 32'(i * 4), v, 1'b0, 4'h0, 32'h0, 32'h0);
            model[i] = v;
            tick();
        end

        // single store then read through lane 1 with a nonzero byte offset
        drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        check("t1_stop", 32'(stop), 32'h0);
        tick();
        read_check("t1_read", 32'h0, 32'h12, model[0], 32'hDEADBEEF);

        drive(1'b1, 4'b0100, 32'h10, 32'h00AA0000, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        read_check("t2_merge", 32'h10, 32'h10, 32'hDEAABEEF, 32'hDEAABEEF);

        // forwarding from lane 0 to lane 1, never the other way
        drive(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 4'b0011, 32'h20, 32'h00001234, 1'b0, 4'h0, 32'h20, 32'h0);
        #4;
        check("t3_fwd_rdata1", rdata1, 32'hFFFF1234);
        check("t3_fwd_rdata0", rdata0, 32'hFFFFFFFF);
        tick();
        drive(1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 4'hF, 32'h20, 32'h55555555);
        #4;
        check("t3_norev_rdata0", rdata0, 32'hFFFF1234);
        check("t3_norev_stop", 32'(stop), 32'h0);
        tick();
        read_check("t3_after", 32'h20, 32'h20, 32'h55555555, 32'h55555555);

        // double store to the same word
        drive(1'b1, 4'hF, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 4'hF, 32'h40, 32'h11111111, 1'b1, 4'b0001, 32'h40, 32'h00000022);
        #4;
        check("t4_stop_first", 32'(stop), 32'h1);
        check("t4_fwd_rdata1", rdata1, 32'h11111111);
        tick();
        #4;
        check("t4_stop_second", 32'(stop), 32'h0);
        check("t4_second_rdata1", rdata1, 32'h11111111);
        tick();
        read_check("t4_final", 32'h40, 32'h40, 32'h11111122, 32'h11111122);

        // reset during SECOND drops the pending lane 1 store
        drive(1'b1, 4'hF, 32'h50, 32'hAAAAAAAA, 1'b1, 4'hF, 32'h54, 32'hBBBBBBBB);
        #4;
        check("t5_stop_first", 32'(stop), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model[20] = 32'hAAAAAAAA;
        read_check("t5_after_rst", 32'h50, 32'h54, model[20], model[21]);
        drive(1'b1, 4'hF, 32'h58, 32'h00000001, 1'b1, 4'hF, 32'h5C, 32'h00000002);
        #4;
        check("t5_idle_after_rst", 32'(stop), 32'h1);
        tick();
        #4;
        check("t5_second_again", 32'(stop), 32'h0);
        tick();
        model[22] = 32'h1;
        model[23] = 32'h2;
        read_check("t5_double_again", 32'h58, 32'h5C, 32'h1, 32'h2);

        // randomized traffic over a 16-word window to force index collisions
        for (int it = 0; it < 200; it++) begin
            w0 = 1'($urandom); e0 = 4'($urandom); a0 = 32'h100 + 32'($urandom_range(0, 63)); d0 = $urandom;
            w1 = 1'($urandom); e1 = 4'($urandom); a1 = 32'h100 + 32'($urandom_range(0, 63)); d1 = $urandom;
            i0 = int'(a0 >> 2);
            i1 = int'(a1 >> 2);
            ew0 = w0 && (e0 != 4'h0);
            ew1 = w1 && (e1 != 4'h0);
            exp1 = (ew0 && i0 == i1) ? merge(model[i1], d0, e0) : model[i1];
            drive(w0, e0, a0, d0, w1, e1, a1, d1);
            #4;
            check("rnd_rdata0", rdata0, model[i0]);
            check("rnd_rdata1", rdata1, exp1);
            check("rnd_stop", 32'(stop), 32'(ew0 && ew1));
            tick();
            if (ew0) model[i0] = merge(model[i0], d0, e0);
            if (ew1 && !ew0) model[i1] = merge(model[i1], d1, e1);
            if (ew0 && ew1) begin
                #4;
                check("rnd_hold_rdata0", rdata0, model[i0]);
                check("rnd_hold_rdata1", rdata1, model[i1]);
                check("rnd_hold_stop", 32'(stop), 32'h0);
                tick();
                model[i1] = merge(model[i1], d1, e1);
            end
        end
        for (int i = 64; i < 80; i += 2) begin
            read_check("rnd_final", 32'(i * 4), 32'(i * 4 + 4), model[i], model[i + 1]);
        end
        check("err_quiet", 32'(err), 32'h0);

        // out-of-range store: no write, zero read, sticky err
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
        #4;
        check("t6_oob_rdata1", rdata1, 32'h0);
        check("t6_err_before", 32'(err), 32'h0);
        check("t6_oob_stop", 32'(stop), 32'h0);
        tick();
        read_check("t6_no_wrap", 32'h0, 32'h0, model[0], model[0]);
        check("t6_err_set", 32'(err), 32'h1);
        tick();
        tick();
        check("t6_err_held", 32'(err), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_err_cleared", 32'(err), 32'h0);
        drive(1'b0, 4'h0, 32'h2000, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        #4;
        check("t6_oob_read_rdata0", rdata0, 32'h0);
        tick();
        check("t6_oob_read_err", 32'(err), 32'h1);
        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_idle_no_err", 32'(err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
